// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide unit for the execute stage.
// One radix-2 shift-add (multiply) or restoring-divide step per cycle, followed
// by a sign / width fix-up cycle. Handshake is valid/ready on both sides.
//
// Build option: define MUL_DIV_FAST_MUL_EN to resolve multiplies with a single
// combinational multiplier in PREP (PREP -> FIX). Divide timing is unaffected.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a request, in_ready high
// PREP  | truncate operands, take magnitudes, record signs, detect specials
// CALC  | one multiply or divide step per edge until the counter expires
// FIX   | apply signs, select result half, sign-extend word results, latch
// DONE  | result presented with out_valid until out_ready

module mul_div_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         kill,
    input  logic         word,
    input  logic [2:0]   op,
    input  logic [N-1:0] dataA,
    input  logic [N-1:0] dataB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         div_by_zero
);

    localparam int           WORD_N    = 32;
    localparam int           CW        = $clog2(N + 1);
    localparam bit           WIDE      = (N == 64);
    localparam logic [N-1:0] MASK_WORD = N'({WORD_N{1'b1}});

`ifdef MUL_DIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    // latched request
    logic [2:0]     op_q;
    logic           word_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;

    // flags recorded in PREP
    logic           neg_res;
    logic           neg_rem;
    logic           sp_dz;
    logic           sp_ovf;
    logic           sp_ill;

    // iteration datapath
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] prod;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   dvd;
    logic [N-1:0]   rem;
    logic [N-1:0]   dvsr;

    // decode / prep signals
    logic           w32;
    logic           is_div;
    logic [N-1:0]   mask_w;
    logic [N-1:0]   a_t;
    logic [N-1:0]   b_t;
    logic           sgn_a;
    logic           sgn_b;
    logic           sgn_op_a;
    logic           sgn_op_b;
    logic           neg_a;
    logic           neg_b;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic           dz_det;
    logic           ovf_det;
    logic           ill_det;
    logic           special;

    // divide step signals
    logic           top_bit;
    logic [N:0]     trial;
    logic [N:0]     diff;
    logic           q_bit;
    logic [N-1:0]   rem_step;

    // fix-up signals
    logic [2*N-1:0] prod_s;
    logic [N-1:0]   mul_hi;
    logic [N-1:0]   mul_res;
    logic [N-1:0]   quo;
    logic [N-1:0]   rmd;
    logic [N-1:0]   raw;
    logic [N-1:0]   fix_res;

    // Operand width selection, magnitudes and special-case detection
    always_comb begin
        w32      = word_q & WIDE;
        is_div   = op_q[2];
        mask_w   = w32 ? MASK_WORD : {N{1'b1}};
        a_t      = a_q & mask_w;
        b_t      = b_q & mask_w;
        sgn_a    = w32 ? a_q[WORD_N-1] : a_q[N-1];
        sgn_b    = w32 ? b_q[WORD_N-1] : b_q[N-1];
        // DIV/REM: both signed; MULH: both; MULHSU: A only; MUL and unsigned ops: none
        sgn_op_a = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
        sgn_op_b = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
        neg_a    = sgn_op_a & sgn_a;
        neg_b    = sgn_op_b & sgn_b;
        a_mag    = neg_a ? ((-a_t) & mask_w) : a_t;
        b_mag    = neg_b ? ((-b_t) & mask_w) : b_t;
        dz_det   = is_div & (b_t == '0);
        ovf_det  = is_div & ~op_q[0] & (a_t == (mask_w ^ (mask_w >> 1))) & (b_t == mask_w);
        ill_det  = ~is_div & w32 & (op_q[1:0] != 2'b00);
        special  = dz_det | ovf_det | ill_det;
    end

    // Restoring-divide step: the next dividend bit comes from bit W-1
    always_comb begin
        top_bit  = w32 ? dvd[WORD_N-1] : dvd[N-1];
        trial    = {rem, top_bit};
        diff     = trial - {1'b0, dvsr};
        q_bit    = ~diff[N];
        rem_step = q_bit ? diff[N-1:0] : trial[N-1:0];
    end

    // Sign application, half selection and word sign extension
    always_comb begin
        prod_s  = neg_res ? (-prod) : prod;
        mul_hi  = w32 ? N'(prod_s >> WORD_N) : prod_s[2*N-1:N];
        if (sp_ill) begin
            mul_res = '0;
        end else if (op_q[1:0] == 2'b00) begin
            mul_res = prod_s[N-1:0];
        end else begin
            mul_res = mul_hi;
        end

        if (sp_dz) begin
            quo = '1;
            rmd = a_t;
        end else if (sp_ovf) begin
            quo = a_t;
            rmd = '0;
        end else begin
            quo = neg_res ? (-dvd) : dvd;
            rmd = neg_rem ? (-rem) : rem;
        end

        raw = is_div ? (op_q[1] ? rmd : quo) : mul_res;

        // word results (including DIVUW/REMUW) are sign-extended from bit 31
        if (w32) begin
            fix_res = raw[WORD_N-1] ? (raw | ~MASK_WORD) : (raw & MASK_WORD);
        end else begin
            fix_res = raw;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; kill overrides every transition
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = PREP;
                end
            end
            PREP: begin
                if (special || (FAST_MUL && !is_div)) begin
                    state_nxt = FIX;
                end else begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (kill) begin
            state_nxt = IDLE;
        end
    end

    // Request capture, iteration datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= '0;
            word_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            sp_dz       <= 1'b0;
            sp_ovf      <= 1'b0;
            sp_ill      <= 1'b0;
            cnt         <= '0;
            prod        <= '0;
            mcand       <= '0;
            mplier      <= '0;
            dvd         <= '0;
            rem         <= '0;
            dvsr        <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !kill) begin
                        op_q   <= op;
                        word_q <= word;
                        a_q    <= dataA;
                        b_q    <= dataB;
                    end
                end
                PREP: begin
                    neg_res <= neg_a ^ neg_b;
                    neg_rem <= neg_a;
                    sp_dz   <= dz_det;
                    sp_ovf  <= ovf_det;
                    sp_ill  <= ill_det;
                    cnt     <= w32 ? CW'(WORD_N) : CW'(N);
                    prod    <= '0;
                    mcand   <= {{N{1'b0}}, a_mag};
                    mplier  <= b_mag;
                    dvd     <= a_mag;
                    rem     <= '0;
                    dvsr    <= b_mag;
`ifdef MUL_DIV_FAST_MUL_EN
                    if (!is_div) begin
                        prod <= {{N{1'b0}}, a_mag} * {{N{1'b0}}, b_mag};
                    end
`endif
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_div) begin
                        rem <= rem_step;
                        dvd <= {dvd[N-2:0], q_bit};
                    end else begin
                        if (mplier[0]) begin
                            prod <= prod + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    if (!kill) begin
                        result      <= fix_res;
                        div_by_zero <= sp_dz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit (N=64): directed vectors, an arithmetic reference
// model, and a negedge monitor that checks every cycle out_valid is high.
`timescale 1ns/1ps

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        kill;
    logic        word;
    logic [2:0]  op;
    logic [63:0] dataA;
    logic [63:0] dataB;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic        exp_active = 1'b0;
    logic [63:0] exp_res    = '0;
    logic        exp_dz     = 1'b0;
    int          exp_lat    = 0;
    int          acc_cyc    = 0;
    bit          lat_seen   = 1'b0;

`ifdef MUL_DIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    mul_div_unit #(.N(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .kill        (kill),
        .word        (word),
        .op          (op),
        .dataA       (dataA),
        .dataB       (dataB),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: RISC-V M semantics in plain arithmetic
    task automatic model(input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res,
                         output logic dz, output int lat);
        logic [31:0]         a32;
        logic [31:0]         b32;
        logic [31:0]         r32;
        logic signed [127:0] pa;
        logic signed [127:0] pb;
        logic signed [127:0] pp;
        bit                  spec;
        a32  = a[31:0];
        b32  = b[31:0];
        r32  = '0;
        res  = '0;
        dz   = 1'b0;
        spec = 1'b0;
        if (w) begin
            case (o)
                3'd0: r32 = a32 * b32;
                3'd1, 3'd2, 3'd3: begin r32 = '0; spec = 1'b1; end
                3'd4: begin
                    if (b32 == 0) begin r32 = '1; dz = 1'b1; end
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin r32 = a32; spec = 1'b1; end
                    else r32 = 32'($signed(a32) / $signed(b32));
                end
                3'd5: begin
                    if (b32 == 0) begin r32 = '1; dz = 1'b1; end
                    else r32 = a32 / b32;
                end
                3'd6: begin
                    if (b32 == 0) begin r32 = a32; dz = 1'b1; end
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin r32 = '0; spec = 1'b1; end
                    else r32 = 32'($signed(a32) % $signed(b32));
                end
                default: begin
                    if (b32 == 0) begin r32 = a32; dz = 1'b1; end
                    else r32 = a32 % b32;
                end
            endcase
            res = {{32{r32[31]}}, r32};
        end else begin
            case (o)
                3'd0: res = a * b;
                3'd1: begin
                    pa = $signed({{64{a[63]}}, a}); pb = $signed({{64{b[63]}}, b});
                    pp = pa * pb; res = pp[127:64];
                end
                3'd2: begin
                    pa = $signed({{64{a[63]}}, a}); pb = $signed({64'd0, b});
                    pp = pa * pb; res = pp[127:64];
                end
                3'd3: begin
                    pa = $signed({64'd0, a}); pb = $signed({64'd0, b});
                    pp = pa * pb; res = pp[127:64];
                end
                3'd4: begin
                    if (b == 0) begin res = '1; dz = 1'b1; end
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) begin res = a; spec = 1'b1; end
                    else res = $signed(a) / $signed(b);
                end
                3'd5: begin
                    if (b == 0) begin res = '1; dz = 1'b1; end
                    else res = a / b;
                end
                3'd6: begin
                    if (b == 0) begin res = a; dz = 1'b1; end
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) begin res = '0; spec = 1'b1; end
                    else res = $signed(a) % $signed(b);
                end
                default: begin
                    if (b == 0) begin res = a; dz = 1'b1; end
                    else res = a % b;
                end
            endcase
        end
        if (dz || spec || (FAST && !o[2])) lat = 2;
        else lat = (w ? 32 : 64) + 2;
    endtask

    // Monitor: every cycle out_valid is high, outputs must match the model
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!exp_active) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                check64("result", result, exp_res);
                check64("div_by_zero", {63'd0, div_by_zero}, {63'd0, exp_dz});
                check64("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                if (!lat_seen) begin
                    lat_seen = 1'b1;
                    check_int("latency", cyc - acc_cyc, exp_lat);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after a rising edge
    task automatic run_op(input logic [2:0] o, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input bit pin,
                          input logic [63:0] pin_res, input logic pin_dz);
        logic [63:0] mr;
        logic        md;
        int          ml;
        int          t;
        model(o, w, a, b, mr, md, ml);
        if (pin) begin
            check64("model_pin_result", mr, pin_res);
            check64("model_pin_dz", {63'd0, md}, {63'd0, pin_dz});
        end
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check64("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            return;
        end
        op = o; word = w; dataA = a; dataB = b; in_valid = 1'b1;
        exp_res = mr; exp_dz = md; exp_lat = ml; lat_seen = 1'b0; exp_active = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        dataA    = {$urandom, $urandom};
        dataB    = {$urandom, $urandom};
        op       = 3'($urandom_range(0, 7));
        word     = 1'($urandom_range(0, 1));
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            check64("out_valid_timeout", {63'd0, out_valid}, 64'd1);
            exp_active = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        exp_active = 1'b0;
        @(negedge clk);
        check64("out_valid_after_take", {63'd0, out_valid}, 64'd0);
        check64("in_ready_after_take", {63'd0, in_ready}, 64'd1);
        check64("result_held_idle", result, mr);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; word = 1'b0; op = '0;
        dataA = '0; dataB = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check64("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("rst_result", result, 64'd0);
        check64("rst_dz", {63'd0, div_by_zero}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
        run_op(3'd3, 1'b0, '1, '1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op(3'd1, 1'b0, '1, '1, 1, 64'h0, 1'b0);
        run_op(3'd4, 1'b0, -64'sd7, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op(3'd6, 1'b0, -64'sd7, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(3'd5, 1'b0, 64'd100, 64'd7, 1, 64'd14, 1'b0);
        run_op(3'd5, 1'b0, 64'h1234, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        run_op(3'd7, 1'b0, 64'h1234, 64'd0, 1, 64'h1234, 1'b1);

        // asynchronous reset in the middle of CALC
        op = 3'd0; word = 1'b0; dataA = 64'd12345; dataB = 64'd678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check64("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check64("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("midrst_result", result, 64'd0);
        check64("midrst_dz", {63'd0, div_by_zero}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 1, 64'hFFFF_FFFF_8000_0000, 1'b0);
        run_op(3'd6, 1'b1, 64'h0000_0000_8000_0000, '1, 1, 64'h0, 1'b0);
        run_op(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op(3'd2, 1'b0, -64'sd2, 64'd3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000, 1'b0);
        run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 64'h0, 1'b0);
        run_op(3'd7, 1'b1, 64'hABCD_0000_FFFF_FFFF, 64'h10, 1, 64'hF, 1'b0);
        run_op(3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op(3'd1, 1'b1, 64'h1234, 64'h5678, 1, 64'h0, 1'b0);
        run_op(3'd4, 1'b1, 64'h5555_0000_FFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op(3'd6, 1'b1, 64'h0000_0001_8000_0005, 64'hFFFF_FFFF_0000_0000, 1, 64'hFFFF_FFFF_8000_0005, 1'b1);
        run_op(3'd4, 1'b0, 64'd7, -64'sd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op(3'd6, 1'b0, 64'd7, -64'sd2, 1, 64'd1, 1'b0);
        run_op(3'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0, '0, 1'b0);
        run_op(3'd2, 1'b0, '1, '1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // kill during CALC: no result may ever appear
        op = 3'd4; word = 1'b0; dataA = -64'sd1000; dataB = 64'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        check64("kill_in_ready", {63'd0, in_ready}, 64'd1);
        check64("kill_out_valid", {63'd0, out_valid}, 64'd0);
        repeat (80) @(posedge clk);
        #1;
        run_op(3'd0, 1'b0, 64'd3, 64'd5, 1, 64'd15, 1'b0);

        // kill together with in_valid in IDLE: request is not accepted
        op = 3'd0; word = 1'b0; dataA = 64'd9; dataB = 64'd9; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        @(negedge clk);
        check64("kill_wins_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (80) @(posedge clk);
        #1;
        run_op(3'd5, 1'b0, 64'd1000, 64'd10, 1, 64'd100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
